multi_zone_irrigation_ctrl: RTL and testbench
=============================================

// Module: multi_zone_irrigation_ctrl
// PURPOSE
//   Sequential, parametrised successor of the single-zone irrigation and tank-level logic.
//   - Monitors the tank through the H/M/L level sensors and drives the inlet valve with hysteresis.
//   - Waters ZONES soil zones one at a time under round-robin arbitration.
//   - Uses per-zone timeouts, fill timeout and error/alarm latching.
//   - Sits below the system top, beside the display driver that shows level and active zone.
// PARAMETERS
//   ZONES         4    number of irrigation zones (2..8)
//   TW            8    width of the tick counters
//   MAX_IRR_TICKS 60   ticks a zone valve may stay open before the zone is faulted
//   SETTLE_TICKS  5    ticks with all zone valves closed between zones
//   FILL_TIMEOUT  120  ticks the inlet valve may stay open without reaching H
// PORTS
//   clk         in  1          system clock
//   rest        in  1          synchronous active-high reset
//   tick        in  1          one-cycle time-base strobe; all timers count only on tick
//   H,M,L       in  1          tank sensors, 1 = water at that height
//   Us          in  ZONES      soil dry flag per zone (1 = needs water)
//   Ua          in  ZONES      soil wet flag per zone (1 = saturated)
//   T           in  1          high-temperature flag
//   switch      in  1          system enable
//   Ve          out 1          tank inlet valve
//   Vz          out ZONES      zone valves, one-hot or zero
//   level       out 2          0 empty, 1 low, 2 mid, 3 full
//   Erro        out 1          level-sensor inconsistency
//   Alarme      out 1          latched fault: fill timeout or tank ran dry while irrigating
//   zone_err    out ZONES      latched per-zone fault
//   active_zone out clog2(ZONES) index of the open zone valve (last served zone when idle)
//   busy        out 1          zone FSM not in IDLE
// BEHAVIOUR
//   Reset and registering
//   - Every output and internal register is 0 one cycle after rest=1, including the pointer and counters.
//   - rest wins over every other event; a reset mid-irrigation closes all valves on the next edge.
//   - All outputs are registered; level and Erro lag {H,M,L} by 1 cycle.
//   Level decode
//   - {H,M,L}: 000->0, 001->1, 011->2, 111->3.
//   - Any other code sets Erro=1 and holds level at its previous value.
//   - Erro clears one cycle after a legal code returns.
//   Fill control
//   - Ve sets when M=0 and Erro=0; Ve clears when H=1 or Erro=1.
//   - The fill counter increments on tick while Ve=1 and clears when Ve=0.
//   - Counter reaching FILL_TIMEOUT: set Alarme and force Ve=0 until rest.
//   Zone FSM: IDLE, SCAN, IRRIGATE, SETTLE
//   - IDLE->SCAN when switch=1, L=1 and Erro=0. The scan counter clears on entry.
//   - SCAN examines zone ptr, one per cycle.
//     - If Ua[ptr]&Us[ptr], set zone_err[ptr].
//     - Zone ptr is a candidate if Us=1, Ua=0 and zone_err=0.
//     - Candidate: go to IRRIGATE and open Vz[ptr] on the next cycle.
//     - Non-candidate: advance ptr, wrapping ZONES-1 -> 0.
//     - After ZONES consecutive non-candidates, go back to IDLE.
//   - IRRIGATE: only Vz[active_zone]=1. The irrigation counter increments on tick.
//     - Exit to SETTLE on Ua=1 or Us=0 (normal completion).
//     - Exit to SETTLE on counter == MAX_IRR_TICKS, and set zone_err.
//     - Exit to SETTLE on L=0, and set Alarme.
//     - Exit to SETTLE on switch=0 or Erro=1, with no fault.
//     - If several exit conditions hit in the same cycle, all their fault bits are set.
//     - Vz goes 0 in the cycle SETTLE is entered.
//   - SETTLE: all Vz=0; ptr = active_zone+1 (wrapped).
//     - Wait SETTLE_TICKS ticks, then go to SCAN, or to IDLE if switch=0.
//   - Fairness: a zone cannot be served twice while another candidate waits.
//   - Counters saturate and never wrap.
// CONFIGURATION
//   TEMP_INHIBIT_EN
//   - Defined: T=1 blocks the SCAN->IRRIGATE transition; the zone is treated as a non-candidate
//     but is not faulted. An irrigation already in progress continues to completion.
//   - Undefined: T is ignored.
// TESTING
//   1 rest=1 mid-IRRIGATE (Vz=0010) -> next cycle all outputs 0, ptr=0.
//   2 {H,M,L} 000->001->011->111 -> level 0,1,2,3, each 1 cycle late;
//     Ve=1 from start until H=1; code 101 -> Erro=1 and Ve=0.
//   3 ZONES=4, Us=1111, Ua=0000, then Ua[i] set after 3 ticks of zone i ->
//     zones served in order 0,1,2,3,0, with SETTLE_TICKS gaps and Vz never multi-hot.
//   4 Us[2]=1, Ua=0 held -> after MAX_IRR_TICKS ticks zone_err=0100, zone 2 skipped thereafter.
//   5 Ve=1 with H never 1 -> Alarme=1 at FILL_TIMEOUT ticks, Ve=0 until rest;
//     L=0 while irrigating -> Alarme=1, Vz=0.
//   6 TEMP_INHIBIT_EN defined, T=1, Us=1111 -> no Vz asserted, FSM cycles SCAN/IDLE, zone_err=0.

Source files
------------

// File: rtl/multi_zone_irrigation_ctrl.sv
// multi_zone_irrigation_ctrl
// Tank level decode with inlet-valve hysteresis and a fill watchdog, plus a
// round-robin zone watering FSM (IDLE/SCAN/IRRIGATE/SETTLE) with per-zone
// timeouts and latched faults. All outputs come straight from flops.
// Optional build macro: TEMP_INHIBIT_EN (T=1 holds off new irrigations).
module multi_zone_irrigation_ctrl #(
   parameter int ZONES         = 4,
   parameter int TW            = 8,
   parameter int MAX_IRR_TICKS = 60,
   parameter int SETTLE_TICKS  = 5,
   parameter int FILL_TIMEOUT  = 120
) (
   input  logic                     clk,
   input  logic                     rest,
   input  logic                     tick,
   input  logic                     H,
   input  logic                     M,
   input  logic                     L,
   input  logic [ZONES-1:0]         Us,
   input  logic [ZONES-1:0]         Ua,
   input  logic                     T,
   input  logic                     switch,
   output logic                     Ve,
   output logic [ZONES-1:0]         Vz,
   output logic [1:0]               level,
   output logic                     Erro,
   output logic                     Alarme,
   output logic [ZONES-1:0]         zone_err,
   output logic [$clog2(ZONES)-1:0] active_zone,
   output logic                     busy
);
   localparam int AW = $clog2(ZONES);
`ifdef TEMP_INHIBIT_EN
   localparam logic TEMP_INHIBIT = 1'b1;
`else
   localparam logic TEMP_INHIBIT = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_IRRIGATE, S_SETTLE} state_t;

   state_t           state_q;
   logic [1:0]       level_q, level_d;
   logic             erro_q, erro_d;
   logic             ve_q, ve_d;
   logic [TW-1:0]    fill_cnt_q, fill_cnt_d;
   logic             fill_lock_q, fill_lock_d;
   logic             fill_hit;
   logic             alarm_q;
   logic [ZONES-1:0] vz_q, zone_err_q;
   logic [AW-1:0]    ptr_q, active_zone_q, scan_cnt_q;
   logic [TW-1:0]    irr_cnt_q, settle_cnt_q;
   logic             busy_q;
   logic [AW-1:0]    ptr_inc, az_inc;
   logic             cand, both_flags;
   logic             exit_norm, exit_to, exit_dry, exit_abort;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Zone index increment wrapping ZONES-1 back to 0.
   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] v);
      return (v == AW'(ZONES - 1)) ? '0 : v + 1'b1;
   endfunction

   // Level decode, inlet valve hysteresis and fill-timeout lock.
   always_comb begin
      level_d = level_q;
      erro_d  = 1'b0;
      case ({H, M, L})
         3'b000:  level_d = 2'd0;
         3'b001:  level_d = 2'd1;
         3'b011:  level_d = 2'd2;
         3'b111:  level_d = 2'd3;
         default: erro_d  = 1'b1;
      endcase
      fill_hit    = (fill_cnt_q == TW'(FILL_TIMEOUT));
      fill_lock_d = fill_lock_q | fill_hit;
      ve_d        = ve_q;
      if (!M && !erro_q) ve_d = 1'b1;
      // Clearing wins over setting; the watchdog lock overrides everything.
      if (H || erro_q || fill_lock_d) ve_d = 1'b0;
      if (!ve_q)
         fill_cnt_d = '0;
      else if (tick)
         fill_cnt_d = sat_inc(fill_cnt_q);
      else
         fill_cnt_d = fill_cnt_q;
   end

   // Tank-side state registers.
   always_ff @(posedge clk) begin
      if (rest) begin
         level_q     <= '0;
         erro_q      <= 1'b0;
         ve_q        <= 1'b0;
         fill_cnt_q  <= '0;
         fill_lock_q <= 1'b0;
      end else begin
         level_q     <= level_d;
         erro_q      <= erro_d;
         ve_q        <= ve_d;
         fill_cnt_q  <= fill_cnt_d;
         fill_lock_q <= fill_lock_d;
      end
   end

   assign ptr_inc    = wrap_inc(ptr_q);
   assign az_inc     = wrap_inc(active_zone_q);
   assign both_flags = Us[ptr_q] & Ua[ptr_q];
   assign cand       = Us[ptr_q] & ~Ua[ptr_q] & ~zone_err_q[ptr_q] & ~(TEMP_INHIBIT & T);
   assign exit_norm  = Ua[active_zone_q] | ~Us[active_zone_q];
   assign exit_to    = (irr_cnt_q == TW'(MAX_IRR_TICKS));
   assign exit_dry   = ~L;
   assign exit_abort = ~switch | erro_q;

   // Zone FSM with registered valve, pointer, fault and busy outputs.
   always_ff @(posedge clk) begin
      if (rest) begin
         state_q       <= S_IDLE;
         vz_q          <= '0;
         zone_err_q    <= '0;
         ptr_q         <= '0;
         active_zone_q <= '0;
         scan_cnt_q    <= '0;
         irr_cnt_q     <= '0;
         settle_cnt_q  <= '0;
         busy_q        <= 1'b0;
         alarm_q       <= 1'b0;
      end else begin
         alarm_q <= alarm_q | fill_hit | ((state_q == S_IRRIGATE) & exit_dry);
         case (state_q)
            S_IDLE: begin
               if (switch && L && !erro_q) begin
                  state_q    <= S_SCAN;
                  scan_cnt_q <= '0;
                  busy_q     <= 1'b1;
               end
            end
            S_SCAN: begin
               if (both_flags) zone_err_q[ptr_q] <= 1'b1;
               if (cand) begin
                  state_q       <= S_IRRIGATE;
                  vz_q          <= ZONES'(1) << ptr_q;
                  active_zone_q <= ptr_q;
                  irr_cnt_q     <= '0;
               end else begin
                  ptr_q <= ptr_inc;
                  if (scan_cnt_q == AW'(ZONES - 1)) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     scan_cnt_q <= scan_cnt_q + 1'b1;
                  end
               end
            end
            S_IRRIGATE: begin
               if (tick) irr_cnt_q <= sat_inc(irr_cnt_q);
               if (exit_norm || exit_to || exit_dry || exit_abort) begin
                  state_q      <= S_SETTLE;
                  vz_q         <= '0;
                  settle_cnt_q <= '0;
                  ptr_q        <= az_inc;
                  if (exit_to) zone_err_q[active_zone_q] <= 1'b1;
               end
            end
            default: begin
               if (settle_cnt_q == TW'(SETTLE_TICKS)) begin
                  if (switch) begin
                     state_q    <= S_SCAN;
                     scan_cnt_q <= '0;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else if (tick) begin
                  settle_cnt_q <= sat_inc(settle_cnt_q);
               end
            end
         endcase
      end
   end

   assign Ve          = ve_q;
   assign Vz          = vz_q;
   assign level       = level_q;
   assign Erro        = erro_q;
   assign Alarme      = alarm_q;
   assign zone_err    = zone_err_q;
   assign active_zone = active_zone_q;
   assign busy        = busy_q;
endmodule

// File: tb/tb_multi_zone_irrigation_ctrl.sv
// Directed bench for multi_zone_irrigation_ctrl with small timing parameters.
module tb_multi_zone_irrigation_ctrl;
   localparam int ZONES  = 4;
   localparam int TW     = 8;
   localparam int MAXIRR = 10;
   localparam int SETTLE = 3;
   localparam int FILLTO = 20;

   logic             clk = 1'b0;
   logic             rest, tick, H, M, L, T, sw;
   logic [ZONES-1:0] Us, Ua;
   logic             Ve, Erro, Alarme, busy;
   logic [ZONES-1:0] Vz, zone_err;
   logic [1:0]       level;
   logic [1:0]       active_zone;

   int n_total = 0;
   int n_bad   = 0;

   multi_zone_irrigation_ctrl #(
      .ZONES(ZONES), .TW(TW), .MAX_IRR_TICKS(MAXIRR),
      .SETTLE_TICKS(SETTLE), .FILL_TIMEOUT(FILLTO)
   ) dut (
      .clk(clk), .rest(rest), .tick(tick), .H(H), .M(M), .L(L),
      .Us(Us), .Ua(Ua), .T(T), .switch(sw),
      .Ve(Ve), .Vz(Vz), .level(level), .Erro(Erro), .Alarme(Alarme),
      .zone_err(zone_err), .active_zone(active_zone), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: got=%0h", tag, got);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_hml(input logic [2:0] c);
      {H, M, L} = c;
   endtask

   task automatic do_reset();
      rest = 1'b1;
      step(1);
      rest = 1'b0;
   endtask

   task automatic wait_vz(input string tag, input logic [ZONES-1:0] target, input int budget);
      for (int i = 0; i < budget && Vz !== target; i++) step(1);
      chk(tag, Vz, target);
   endtask

   function automatic int oh2idx(input logic [ZONES-1:0] v);
      for (int i = 0; i < ZONES; i++) if (v[i]) return i;
      return -1;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int served[$];
      int gap, on_cnt, multihot, seen;
      logic [ZONES-1:0] prev;

      rest = 1'b0; tick = 1'b1; T = 1'b0; sw = 1'b0;
      Us = '0; Ua = '0; set_hml(3'b000);
      @(negedge clk);

      // Level decode, Erro and inlet hysteresis
      do_reset();
      chk("rst_level", level, 0);
      chk("rst_ve", Ve, 0);
      step(1);
      chk("lvl_000", level, 0);
      chk("ve_empty", Ve, 1);
      set_hml(3'b001); #2;
      chk("lvl_lag", level, 0);
      step(1);
      chk("lvl_001", level, 1);
      chk("ve_low", Ve, 1);
      set_hml(3'b011); step(1);
      chk("lvl_011", level, 2);
      chk("ve_mid_hold", Ve, 1);
      set_hml(3'b111); step(1);
      chk("lvl_111", level, 3);
      chk("ve_full_off", Ve, 0);
      chk("erro_legal", Erro, 0);
      set_hml(3'b101); step(1);
      chk("erro_101", Erro, 1);
      chk("lvl_hold_101", level, 3);
      chk("ve_101", Ve, 0);
      set_hml(3'b111); step(1);
      chk("erro_clear", Erro, 0);
      set_hml(3'b001); step(1);
      chk("ve_refill", Ve, 1);
      set_hml(3'b010); step(2);
      chk("erro_010", Erro, 1);
      chk("lvl_hold_010", level, 1);
      chk("ve_erro_off", Ve, 0);

      // Fill timeout: no counting without tick, then alarm and lock until reset
      set_hml(3'b001); sw = 1'b0;
      do_reset();
      step(1);
      chk("fill_ve_on", Ve, 1);
      tick = 1'b0;
      step(FILLTO + 5);
      chk("fill_notick", Alarme, 0);
      tick = 1'b1;
      step(FILLTO - 1);
      chk("fill_pre_alarm", Alarme, 0);
      chk("fill_pre_ve", Ve, 1);
      step(2);
      chk("fill_alarm", Alarme, 1);
      chk("fill_ve_off", Ve, 0);
      step(5);
      chk("fill_ve_locked", Ve, 0);
      do_reset();
      step(1);
      chk("fill_rest_alarm", Alarme, 0);
      chk("fill_rest_ve", Ve, 1);

      // Round robin over four zones, each satisfied after three cycles open
      set_hml(3'b111); Us = 4'b1111; Ua = '0; sw = 1'b1;
      do_reset();
      gap = 0; on_cnt = 0; multihot = 0; prev = '0;
      for (int c = 0; c < 300 && served.size() < 5; c++) begin
         step(1);
         if ($countones(Vz) > 1) multihot++;
         if (Vz != '0) begin
            if (prev == '0) begin
               if (served.size() > 0) chk("rr_gap", 32'(gap >= SETTLE), 1);
               served.push_back(oh2idx(Vz));
               gap = 0;
               on_cnt = 0;
            end
            on_cnt++;
            if (on_cnt == 3) Ua = Vz;
         end else begin
            if (prev != '0) Ua = '0;
            gap++;
         end
         prev = Vz;
      end
      chk("rr_count", served.size(), 5);
      for (int i = 0; i < served.size(); i++) chk($sformatf("rr_zone%0d", i), served[i], i % ZONES);
      chk("rr_onehot", multihot, 0);
      chk("rr_no_err", zone_err, 0);

      // Reset mid-irrigation clears everything and restarts the pointer at 0
      Ua = '0; Us = 4'b0010;
      do_reset();
      wait_vz("rst_mid_open", 4'b0010, 20);
      rest = 1'b1; Us = 4'b1111;
      step(1);
      rest = 1'b0;
      chk("rst_vz", Vz, 0);
      chk("rst_ve2", Ve, 0);
      chk("rst_level2", level, 0);
      chk("rst_erro", Erro, 0);
      chk("rst_alarme", Alarme, 0);
      chk("rst_zone_err", zone_err, 0);
      chk("rst_active", active_zone, 0);
      chk("rst_busy", busy, 0);
      wait_vz("rst_ptr_zero", 4'b0001, 20);

      // Zone timeout faults zone 2, which is then skipped
      Us = 4'b0100; Ua = '0;
      do_reset();
      wait_vz("to_open", 4'b0100, 20);
      chk("to_active", active_zone, 2);
      step(MAXIRR - 1);
      chk("to_pre_err", zone_err, 0);
      chk("to_pre_vz", Vz, 4'b0100);
      step(2);
      chk("to_err", zone_err, 4'b0100);
      chk("to_vz_off", Vz, 0);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         step(1);
         if (Vz != '0) seen++;
      end
      chk("to_skipped", seen, 0);
      chk("to_err_kept", zone_err, 4'b0100);
      chk("to_no_alarm", Alarme, 0);

      // Dry and saturated at once marks the zone faulty during scan
      Us = 4'b0010; Ua = 4'b0010;
      do_reset();
      step(6);
      chk("both_err", zone_err, 4'b0010);
      chk("both_vz", Vz, 0);

      // Tank runs dry while irrigating
      Us = 4'b0001; Ua = '0;
      do_reset();
      wait_vz("dry_open", 4'b0001, 20);
      set_hml(3'b000);
      step(1);
      chk("dry_alarm", Alarme, 1);
      chk("dry_vz", Vz, 0);
      chk("dry_erro", Erro, 0);

      // Switch off aborts without fault and the FSM returns to idle
      set_hml(3'b111); Us = 4'b0001; Ua = '0; sw = 1'b1;
      do_reset();
      wait_vz("abort_open", 4'b0001, 20);
      sw = 1'b0;
      step(1);
      chk("abort_vz", Vz, 0);
      chk("abort_err", zone_err, 0);
      chk("abort_alarm", Alarme, 0);
      chk("abort_busy_settle", busy, 1);
      step(SETTLE + 2);
      chk("abort_idle", busy, 0);

`ifdef TEMP_INHIBIT_EN
      // High temperature blocks new irrigations without faulting zones
      set_hml(3'b111); Us = 4'b1111; Ua = '0; sw = 1'b1; T = 1'b1;
      do_reset();
      seen = 0; gap = 0; on_cnt = 0;
      for (int c = 0; c < 30; c++) begin
         step(1);
         if (Vz != '0) seen++;
         if (busy) gap++; else on_cnt++;
      end
      chk("temp_no_vz", seen, 0);
      chk("temp_no_err", zone_err, 0);
      chk("temp_cycles", 32'((gap > 0) && (on_cnt > 0)), 1);
      T = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
